// File: rtl/len5_pkg.sv
// Shared widths, boot address and front-end handshake structs for the LEN5 core.
package len5_pkg;
  localparam int XLEN       = 64;
  localparam int ILEN       = 32;
  localparam int LINE_WORDS = 4;
  localparam logic [XLEN-1:0] BOOT_PC = '0;

  typedef struct packed {
    logic [XLEN-1:0]                  pc;
    logic [LINE_WORDS-1:0][ILEN-1:0]  line;
  } icache_out_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            taken;
  } prediction_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            taken;
    logic            mispredict;
  } resolution_t;

  // 2-bit saturating counter step
  function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction
endpackage

// File: rtl/branch_predictor.sv
// gshare direction predictor plus direct-mapped BTB; combinational lookup,
// training on resolved branches from the execution stage.
module branch_predictor
  import len5_pkg::*;
#(
  parameter int HLEN     = 4,
  parameter int BTB_BITS = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [XLEN-1:0] lookup_pc_i,
  output prediction_t     lookup_pred_o,
  input  resolution_t     res_i
);
  localparam int PHT_N = 1 << HLEN;
  localparam int BTB_N = 1 << BTB_BITS;
  localparam int TAG_W = XLEN - BTB_BITS - 2;

  typedef struct packed {
    logic            valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0] target;
  } btb_entry_t;

  logic [HLEN-1:0]           ghr_q;
  logic [PHT_N-1:0][1:0]     pht_q;
  btb_entry_t [BTB_N-1:0]    btb_q;

  logic [HLEN-1:0]     lk_pht_idx, tr_pht_idx;
  logic [BTB_BITS-1:0] lk_btb_idx, tr_btb_idx;
  logic [TAG_W-1:0]    lk_tag, tr_tag;
  logic                hit;
  logic [2:0]          unused_res;

  assign lk_pht_idx = lookup_pc_i[HLEN+1:2] ^ ghr_q;
  assign lk_btb_idx = lookup_pc_i[BTB_BITS+1:2];
  assign lk_tag     = lookup_pc_i[XLEN-1:BTB_BITS+2];
  assign hit        = btb_q[lk_btb_idx].valid && (btb_q[lk_btb_idx].tag == lk_tag);

  assign lookup_pred_o.pc     = lookup_pc_i;
  assign lookup_pred_o.taken  = hit & pht_q[lk_pht_idx][1];
  assign lookup_pred_o.target = hit ? btb_q[lk_btb_idx].target : lookup_pc_i + XLEN'(4);

  assign tr_pht_idx = res_i.pc[HLEN+1:2] ^ ghr_q;
  assign tr_btb_idx = res_i.pc[BTB_BITS+1:2];
  assign tr_tag     = res_i.pc[XLEN-1:BTB_BITS+2];
  assign unused_res = {res_i.mispredict, res_i.pc[1:0]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ghr_q <= '0;
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
      btb_q <= '0;
    end else if (res_i.valid) begin
      ghr_q             <= {ghr_q[HLEN-2:0], res_i.taken};
      pht_q[tr_pht_idx] <= sat2(pht_q[tr_pht_idx], res_i.taken);
      if (res_i.taken) begin
        btb_q[tr_btb_idx].valid  <= 1'b1;
        btb_q[tr_btb_idx].tag    <= tr_tag;
        btb_q[tr_btb_idx].target <= res_i.target;
      end
    end
  end
endmodule

// File: rtl/len5_front_end.sv
// LEN5 fetch front end: PC generation, single-outstanding i-cache fetch,
// prediction tagging and a one-entry output register toward issue.
module len5_front_end #(
  parameter int                         HLEN     = 4,
  parameter int                         BTB_BITS = 4,
  parameter logic [len5_pkg::XLEN-1:0]  BOOT_PC  = len5_pkg::BOOT_PC
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          flush_i,
  output logic [len5_pkg::XLEN-1:0]     addr_o,
  output logic                          addr_valid_o,
  input  logic                          addr_ready_i,
  input  len5_pkg::icache_out_t         data_i,
  input  logic                          data_valid_i,
  output logic                          data_ready_o,
  input  logic                          issue_ready_i,
  output logic                          issue_valid_o,
  output logic [len5_pkg::ILEN-1:0]     instruction_o,
  output len5_pkg::prediction_t         pred_o,
  input  len5_pkg::resolution_t         res_i,
  input  logic                          except_i,
  input  logic [len5_pkg::XLEN-1:0]     except_pc_i
);
  import len5_pkg::*;

  logic [XLEN-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d;
  logic            pend_q, pend_d, drop_q, drop_d, out_vld_q, out_vld_d;
  logic [ILEN-1:0] instr_q, instr_d;
  prediction_t     pred_q, pred_d, lk_pred;
  logic            mispred, redirect, req_hs, rsp_hs, load;

  branch_predictor #(.HLEN(HLEN), .BTB_BITS(BTB_BITS)) u_bp (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .lookup_pc_i   (pend_pc_q),
    .lookup_pred_o (lk_pred),
    .res_i         (res_i)
  );

  assign mispred      = res_i.valid & res_i.mispredict;
  assign redirect     = except_i | mispred;
  assign addr_o       = pc_q;
  assign addr_valid_o = !pend_q && !redirect;
  assign req_hs       = addr_valid_o & addr_ready_i;
  assign data_ready_o = pend_q && (!out_vld_q || issue_ready_i);
  assign rsp_hs       = data_valid_i & data_ready_o;
  // A response is only used if it is for the pending PC and nothing cancelled it.
  assign load         = rsp_hs && !drop_q && (data_i.pc == pend_pc_q) && !redirect && !flush_i;

  always_comb begin
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    drop_d    = drop_q;
    out_vld_d = out_vld_q & ~issue_ready_i;
    instr_d   = instr_q;
    pred_d    = pred_q;
    if (req_hs) begin
      pend_d    = 1'b1;
      pend_pc_d = pc_q;
      drop_d    = 1'b0;
    end
    if (rsp_hs) begin
      pend_d = 1'b0;
      drop_d = 1'b0;
    end
    if (load) begin
      out_vld_d = 1'b1;
      instr_d   = data_i.line[pend_pc_q[3:2]];
      pred_d    = lk_pred;
      pc_d      = lk_pred.taken ? lk_pred.target : pend_pc_q + XLEN'(4);
    end
    // Anything still in flight after a redirect or flush is stale.
    if (redirect || flush_i) begin
      out_vld_d = 1'b0;
      drop_d    = pend_d;
    end
    if (mispred)  pc_d = res_i.taken ? res_i.target : res_i.pc + XLEN'(4);
    if (except_i) pc_d = except_pc_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q      <= BOOT_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      drop_q    <= 1'b0;
      out_vld_q <= 1'b0;
      instr_q   <= '0;
      pred_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      drop_q    <= drop_d;
      out_vld_q <= out_vld_d;
      instr_q   <= instr_d;
      pred_q    <= pred_d;
    end
  end

  assign issue_valid_o = out_vld_q;
  assign instruction_o = instr_q;
  assign pred_o        = pred_q;
endmodule

// File: tb/tb_len5_front_end.sv
// Directed bench for len5_front_end: fetch, stall, exception, branch training, flush.
module tb_len5_front_end;
  import len5_pkg::*;

  logic            clk_i = 1'b0, rst_n_i = 1'b0, flush_i = 1'b0;
  logic [XLEN-1:0] addr_o;
  logic            addr_valid_o, addr_ready_i = 1'b0;
  icache_out_t     data_i = '0;
  logic            data_valid_i = 1'b0, data_ready_o;
  logic            issue_ready_i = 1'b0, issue_valid_o;
  logic [ILEN-1:0] instruction_o;
  prediction_t     pred_o;
  resolution_t     res_i = '0;
  logic            except_i = 1'b0;
  logic [XLEN-1:0] except_pc_i = '0;

  int n_checks = 0, n_fail = 0;
  logic [3:0][ILEN-1:0] ln0, lnb;

  len5_front_end dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .addr_o(addr_o), .addr_valid_o(addr_valid_o), .addr_ready_i(addr_ready_i),
    .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .issue_ready_i(issue_ready_i), .issue_valid_o(issue_valid_o),
    .instruction_o(instruction_o), .pred_o(pred_o), .res_i(res_i),
    .except_i(except_i), .except_pc_i(except_pc_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  // Presents a response and holds it until the handshake edge (bounded).
  task automatic respond(input logic [XLEN-1:0] pc, input logic [3:0][ILEN-1:0] line);
    int n = 0;
    data_i.pc = pc; data_i.line = line; data_valid_i = 1'b1;
    while (!data_ready_o && n < 20) begin step(); n++; end
    n_checks++;
    if (data_ready_o !== 1'b1) begin n_fail++; $display("FAIL resp_timeout: data_ready_o=%b want 1", data_ready_o); end
    step();
    data_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; addr_ready_i = 1'b1; #1;
    n_checks++; if (addr_o !== 64'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", addr_o); end
    n_checks++; if (addr_valid_o !== 1'b1) begin n_fail++; $display("FAIL reset_addr_valid: got %b want 1", addr_valid_o); end
    n_checks++; if (issue_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_issue_valid: got %b want 0", issue_valid_o); end
    step(); rst_n_i = 1'b1;
    step();
    n_checks++; if (addr_valid_o !== 1'b0) begin n_fail++; $display("FAIL req_pending_blocks: got %b want 0", addr_valid_o); end
  endtask

  task automatic test_fetch();
    respond(64'h0, ln0);
    n_checks++; if (issue_valid_o !== 1'b1) begin n_fail++; $display("FAIL fetch0_valid: got %b want 1", issue_valid_o); end
    n_checks++; if (instruction_o !== ln0[0]) begin n_fail++; $display("FAIL fetch0_instr: got %h want %h", instruction_o, ln0[0]); end
    n_checks++; if (pred_o.taken !== 1'b0) begin n_fail++; $display("FAIL fetch0_taken: got %b want 0", pred_o.taken); end
    n_checks++; if (addr_o !== 64'h4) begin n_fail++; $display("FAIL fetch0_next_pc: got %h want 4", addr_o); end
    n_checks++; if (addr_valid_o !== 1'b1) begin n_fail++; $display("FAIL fetch0_next_req: got %b want 1", addr_valid_o); end
    issue_ready_i = 1'b1;
    respond(64'h4, ln0);
    n_checks++; if (instruction_o !== ln0[1]) begin n_fail++; $display("FAIL fetch4_instr: got %h want %h", instruction_o, ln0[1]); end
    n_checks++; if (pred_o.target !== 64'h8) begin n_fail++; $display("FAIL fetch4_target: got %h want 8", pred_o.target); end
  endtask

  task automatic test_stall();
    issue_ready_i = 1'b0;
    data_i.pc = 64'h8; data_i.line = ln0; data_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (issue_valid_o !== 1'b1 || instruction_o !== ln0[1] || pred_o.pc !== 64'h4)
        begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b i=%h pc=%h want v=1 i=%h pc=4", i, issue_valid_o, instruction_o, pred_o.pc, ln0[1]); end
      n_checks++; if (data_ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_data_ready[%0d]: got %b want 0", i, data_ready_o); end
    end
    issue_ready_i = 1'b1; #1;
    n_checks++; if (data_ready_o !== 1'b1) begin n_fail++; $display("FAIL unstall_data_ready: got %b want 1", data_ready_o); end
    step();
    data_valid_i = 1'b0; issue_ready_i = 1'b0;
    n_checks++; if (instruction_o !== ln0[2] || pred_o.pc !== 64'h8) begin n_fail++; $display("FAIL unstall_load: got %h/%h want %h/8", instruction_o, pred_o.pc, ln0[2]); end
  endtask

  task automatic test_except();
    step();
    except_i = 1'b1; except_pc_i = 64'h2; #1;
    n_checks++; if (addr_valid_o !== 1'b0) begin n_fail++; $display("FAIL except_blocks_req: got %b want 0", addr_valid_o); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (issue_valid_o !== 1'b0 || addr_o !== 64'h2) begin n_fail++; $display("FAIL except_hold[%0d]: got v=%b pc=%h want v=0 pc=2", i, issue_valid_o, addr_o); end
    end
    except_i = 1'b0; #1;
    n_checks++; if (addr_o !== 64'h2) begin n_fail++; $display("FAIL except_release_pc: got %h want 2", addr_o); end
    respond(64'hC, ln0);
    n_checks++; if (issue_valid_o !== 1'b0 || addr_valid_o !== 1'b1 || addr_o !== 64'h2)
      begin n_fail++; $display("FAIL stale_dropped: got v=%b av=%b pc=%h want 0/1/2", issue_valid_o, addr_valid_o, addr_o); end
    respond(64'h0, ln0);
    n_checks++; if (issue_valid_o !== 1'b0 || addr_valid_o !== 1'b1 || addr_o !== 64'h2)
      begin n_fail++; $display("FAIL pc_mismatch_dropped: got v=%b av=%b pc=%h want 0/1/2", issue_valid_o, addr_valid_o, addr_o); end
  endtask

  task automatic test_branch();
    rst_n_i = 1'b0; #1;
    n_checks++; if (addr_o !== 64'h0 || issue_valid_o !== 1'b0) begin n_fail++; $display("FAIL async_reset: got pc=%h v=%b want 0/0", addr_o, issue_valid_o); end
    step(); rst_n_i = 1'b1; addr_ready_i = 1'b0;
    // Three taken branches elsewhere bring the history to 0111 first.
    res_i = '{valid: 1'b1, pc: 64'h204, target: 64'h300, taken: 1'b1, mispredict: 1'b0};
    repeat (3) step();
    res_i = '{valid: 1'b1, pc: 64'h40, target: 64'h100, taken: 1'b1, mispredict: 1'b1}; #1;
    n_checks++; if (addr_valid_o !== 1'b0) begin n_fail++; $display("FAIL mispredict_blocks_req: got %b want 0", addr_valid_o); end
    step();
    n_checks++; if (addr_o !== 64'h100) begin n_fail++; $display("FAIL mispredict_redirect: got %h want 100", addr_o); end
    res_i.mispredict = 1'b0;
    step();
    res_i = '0;
    except_i = 1'b1; except_pc_i = 64'h40;
    step();
    except_i = 1'b0; addr_ready_i = 1'b1;
    n_checks++; if (addr_o !== 64'h40) begin n_fail++; $display("FAIL except_to_branch: got %h want 40", addr_o); end
    respond(64'h40, lnb);
    n_checks++; if (instruction_o !== lnb[0] || pred_o.pc !== 64'h40) begin n_fail++; $display("FAIL branch_instr: got %h/%h want %h/40", instruction_o, pred_o.pc, lnb[0]); end
    n_checks++; if (pred_o.taken !== 1'b1 || pred_o.target !== 64'h100) begin n_fail++; $display("FAIL branch_pred: got t=%b tg=%h want 1/100", pred_o.taken, pred_o.target); end
    n_checks++; if (addr_o !== 64'h100) begin n_fail++; $display("FAIL branch_next_pc: got %h want 100", addr_o); end
  endtask

  task automatic test_flush();
    issue_ready_i = 1'b0;
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    n_checks++; if (issue_valid_o !== 1'b0 || addr_o !== 64'h100 || addr_valid_o !== 1'b0)
      begin n_fail++; $display("FAIL flush_state: got v=%b pc=%h av=%b want 0/100/0", issue_valid_o, addr_o, addr_valid_o); end
    respond(64'h100, ln0);
    n_checks++; if (issue_valid_o !== 1'b0 || addr_valid_o !== 1'b1) begin n_fail++; $display("FAIL flush_dropped: got v=%b av=%b want 0/1", issue_valid_o, addr_valid_o); end
    respond(64'h100, ln0);
    n_checks++; if (issue_valid_o !== 1'b1 || instruction_o !== ln0[0] || pred_o.pc !== 64'h100)
      begin n_fail++; $display("FAIL refetch_after_flush: got v=%b i=%h pc=%h want 1/%h/100", issue_valid_o, instruction_o, pred_o.pc, ln0[0]); end
  endtask

  initial begin
    ln0 = {32'h0030_0193, 32'h0020_0113, 32'h0010_0093, 32'h0000_0013};
    lnb = {32'h0000_0073, 32'h0000_0033, 32'h0000_0023, 32'h0C00_006F};
    test_reset();
    test_fetch();
    test_stall();
    test_except();
    test_branch();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
